// File: rtl/ci_issuer_if.sv
// Request, custom-instruction bus and response signals between the CPU side and ci_issuer.
interface ci_issuer_if;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqCiN;
    logic [31:0] reqValueA;
    logic [31:0] reqValueB;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspResult;
    logic        rspTimeout;
    logic        busy;

    // master: CPU plus responders; slave: the issuer itself
    modport master (
        output reqValid, reqCiN, reqValueA, reqValueB, ciDone, ciResult, rspReady,
        input  reqReady, ciStart, ciN, ciValueA, ciValueB, rspValid, rspResult, rspTimeout, busy
    );
    modport slave (
        input  reqValid, reqCiN, reqValueA, reqValueB, ciDone, ciResult, rspReady,
        output reqReady, ciStart, ciN, ciValueA, ciValueB, rspValid, rspResult, rspTimeout, busy
    );
endinterface

// File: rtl/ci_issuer.sv
// Issues one custom instruction at a time onto the CI bus and returns its result or a timeout abort.
// Accept at N -> ISSUE at N+1 -> response at N+2 earliest; no new request accepted until the response is consumed.
module ci_issuer #(
    parameter int         TIMEOUT = 16,
    parameter logic [7:0] IDLE_CI = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    ci_issuer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        req_ready;
    logic        ci_start;
    logic [7:0]  ci_n;
    logic [31:0] ci_value_a;
    logic [31:0] ci_value_b;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic        busy_r;

    // The ci_* registers double as the latched request for the whole ISSUE/WAIT span.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            req_ready   <= 1'b1;
            ci_start    <= 1'b0;
            ci_n        <= IDLE_CI;
            ci_value_a  <= 32'd0;
            ci_value_b  <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_timeout <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.reqValid) begin
                        state      <= ISSUE;
                        req_ready  <= 1'b0;
                        busy_r     <= 1'b1;
                        ci_start   <= 1'b1;
                        ci_n       <= bus.reqCiN;
                        ci_value_a <= bus.reqValueA;
                        ci_value_b <= bus.reqValueB;
                        wait_cnt   <= 8'd0;
                    end
                end
                ISSUE, WAIT: begin
                    ci_start <= 1'b0;
                    // Completion wins over timeout when both land in the same cycle.
                    if (bus.ciDone || (state == WAIT && wait_cnt == CNT_LAST)) begin
                        state       <= RESPOND;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= bus.ciDone ? bus.ciResult : 32'd0;
                        rsp_timeout <= ~bus.ciDone;
                        ci_n        <= IDLE_CI;
                        ci_value_a  <= 32'd0;
                        ci_value_b  <= 32'd0;
                    end else begin
                        state <= WAIT;
                        if (state == WAIT) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                RESPOND: begin
                    if (bus.rspReady) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reqReady   = req_ready;
    assign bus.ciStart    = ci_start;
    assign bus.ciN        = ci_n;
    assign bus.ciValueA   = ci_value_a;
    assign bus.ciValueB   = ci_value_b;
    assign bus.rspValid   = rsp_valid;
    assign bus.rspResult  = rsp_result;
    assign bus.rspTimeout = rsp_timeout;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_ci_issuer.sv
// Directed bench for ci_issuer (TIMEOUT=4): responses checked by a queue-based scoreboard, timing checked inline.
module tb_ci_issuer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    ci_issuer_if bus();

    ci_issuer #(.TIMEOUT(4), .IDLE_CI(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] result;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic request(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
        bus.reqValid  = 1'b1;
        bus.reqCiN    = n;
        bus.reqValueA = a;
        bus.reqValueB = b;
        tick();
        bus.reqValid  = 1'b0;
    endtask

    // Monitor: every consumed response must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && bus.rspValid && bus.rspReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=0x%0h timeout=%0b required=none", bus.rspResult, bus.rspTimeout);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_result", bus.rspResult, e.result);
                chk("rsp_timeout", {31'd0, bus.rspTimeout}, {31'd0, e.timeout});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.reqValid  = 1'b0;
        bus.reqCiN    = 8'h00;
        bus.reqValueA = 32'd0;
        bus.reqValueB = 32'd0;
        bus.ciDone    = 1'b0;
        bus.ciResult  = 32'd0;
        bus.rspReady  = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_reqReady", {31'd0, bus.reqReady}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rspValid", {31'd0, bus.rspValid}, 32'd0);
        chk("rst_ciStart", {31'd0, bus.ciStart}, 32'd0);
        chk("rst_ciN", {24'd0, bus.ciN}, 32'h00);
        chk("rst_ciValueA", bus.ciValueA, 32'd0);
        chk("rst_rspResult", bus.rspResult, 32'd0);
        chk("rst_rspTimeout", {31'd0, bus.rspTimeout}, 32'd0);

        // Single-cycle instruction: done already in ISSUE.
        exp_q.push_back('{result: 32'h1234, timeout: 1'b0});
        request(8'h17, 32'd2, 32'd0);
        chk("t1_ciStart", {31'd0, bus.ciStart}, 32'd1);
        chk("t1_ciN", {24'd0, bus.ciN}, 32'h17);
        chk("t1_ciValueA", bus.ciValueA, 32'd2);
        chk("t1_reqReady", {31'd0, bus.reqReady}, 32'd0);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        bus.ciDone   = 1'b1;
        bus.ciResult = 32'h1234;
        tick();
        bus.ciDone = 1'b0;
        chk("t1_rspValid_n2", {31'd0, bus.rspValid}, 32'd1);
        chk("t1_ciN_idle", {24'd0, bus.ciN}, 32'h00);
        tick();
        chk("t1_back_idle", {31'd0, bus.reqReady}, 32'd1);
        chk("t1_busy_low", {31'd0, bus.busy}, 32'd0);

        // Multi-cycle instruction: done in the third WAIT cycle.
        exp_q.push_back('{result: 32'hCAFE, timeout: 1'b0});
        request(8'h17, 32'd5, 32'd7);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ciStart", {31'd0, bus.ciStart}, (i == 0) ? 32'd1 : 32'd0);
            chk("t2_ciN_held", {24'd0, bus.ciN}, 32'h17);
            chk("t2_ciValueB_held", bus.ciValueB, 32'd7);
            chk("t2_rspValid_low", {31'd0, bus.rspValid}, 32'd0);
            if (i == 3) begin
                bus.ciDone   = 1'b1;
                bus.ciResult = 32'hCAFE;
            end
            tick();
        end
        bus.ciDone = 1'b0;
        chk("t2_rspValid", {31'd0, bus.rspValid}, 32'd1);
        tick();

        // Timeout: ISSUE at N+1, WAIT N+2..N+5, abort response at N+6.
        exp_q.push_back('{result: 32'd0, timeout: 1'b1});
        request(8'h21, 32'hAAAA, 32'hBBBB);
        for (int k = 1; k <= 5; k++) begin
            chk("t3_rspValid_low", {31'd0, bus.rspValid}, 32'd0);
            chk("t3_busy", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        chk("t3_rspValid_n6", {31'd0, bus.rspValid}, 32'd1);
        chk("t3_ciN_idle", {24'd0, bus.ciN}, 32'h00);
        chk("t3_ciValueA_zero", bus.ciValueA, 32'd0);
        tick();

        // Race: done arrives in the last WAIT cycle and beats the timeout.
        exp_q.push_back('{result: 32'hBEEF, timeout: 1'b0});
        request(8'h22, 32'd1, 32'd1);
        for (int k = 1; k <= 4; k++) tick();
        bus.ciDone   = 1'b1;
        bus.ciResult = 32'hBEEF;
        tick();
        bus.ciDone = 1'b0;
        chk("t4_rspValid", {31'd0, bus.rspValid}, 32'd1);
        chk("t4_rspTimeout", {31'd0, bus.rspTimeout}, 32'd0);
        tick();

        // Backpressure: response held while the CPU stalls, new requests ignored.
        bus.rspReady = 1'b0;
        exp_q.push_back('{result: 32'h5A5A, timeout: 1'b0});
        request(8'h30, 32'd3, 32'd4);
        bus.ciDone   = 1'b1;
        bus.ciResult = 32'h5A5A;
        tick();
        bus.ciDone   = 1'b0;
        bus.ciResult = 32'hFFFF;
        for (int k = 0; k < 5; k++) begin
            bus.reqValid = 1'b1;
            bus.reqCiN   = 8'h99;
            chk("t5_rspValid_hold", {31'd0, bus.rspValid}, 32'd1);
            chk("t5_rspResult_hold", bus.rspResult, 32'h5A5A);
            chk("t5_reqReady_low", {31'd0, bus.reqReady}, 32'd0);
            tick();
        end
        bus.reqValid = 1'b0;
        bus.rspReady = 1'b1;
        tick();
        chk("t5_idle_reqReady", {31'd0, bus.reqReady}, 32'd1);
        exp_q.push_back('{result: 32'h0077, timeout: 1'b0});
        request(8'h42, 32'd9, 32'd9);
        chk("t5_next_ciN", {24'd0, bus.ciN}, 32'h42);
        bus.ciDone   = 1'b1;
        bus.ciResult = 32'h0077;
        tick();
        bus.ciDone = 1'b0;
        tick();

        // Reset while waiting: the instruction vanishes without a response.
        request(8'h33, 32'd6, 32'd6);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rspValid", {31'd0, bus.rspValid}, 32'd0);
        chk("t6_ciN_idle", {24'd0, bus.ciN}, 32'h00);
        chk("t6_reqReady", {31'd0, bus.reqReady}, 32'd1);
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
        bus.ciDone   = 1'b1;
        bus.ciResult = 32'hDEAD;
        for (int k = 0; k < 8; k++) tick();
        bus.ciDone = 1'b0;
        chk("t6_no_rsp", {31'd0, bus.rspValid}, 32'd0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ci_issuer.md
CI_ISSUER -- requirements
Module: ci_issuer

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum WAIT cycles before abort; legal range 1..255.
REQ-002 SHALL have parameter: IDLE_CI, 8'h00, ciN value driven when no instruction is active; never a valid customId.
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: reqValid  input  1  CPU presents a custom instruction.
REQ-006 SHALL have port: reqReady  output  1  issuer accepts a request this cycle.
REQ-007 SHALL have port: reqCiN  input  8  target custom-instruction id.
REQ-008 SHALL have port: reqValueA / reqValueB  input  32 each  operands.
REQ-009 SHALL have port: ciStart  output  1  one-cycle start pulse to responders.
REQ-010 SHALL have port: ciN  output  8  id driven on the CI bus.
REQ-011 SHALL have port: ciValueA / ciValueB  output  32 each  operands on the CI bus.
REQ-012 SHALL have port: ciDone  input  1  responder completion (level).
REQ-013 SHALL have port: ciResult  input  32  responder result, valid when ciDone=1.
REQ-014 SHALL have port: rspValid  output  1  response available to CPU.
REQ-015 SHALL have port: rspReady  input  1  CPU consumes response.
REQ-016 SHALL have port: rspResult  output  32  captured result.
REQ-017 SHALL have port: rspTimeout  output  1  response is a timeout abort.
REQ-018 SHALL have port: busy  output  1  high whenever state is not IDLE (CPU stall request).

Function
REQ-019 SHALL implement FSM with states IDLE, ISSUE, WAIT, RESPOND.
REQ-020 IDLE: reqReady=1; on reqValid=1 latch reqCiN/reqValueA/reqValueB, go ISSUE.
REQ-021 ISSUE: exactly one cycle; ciStart=1; ciN/ciValueA/ciValueB = latched values; wait counter cleared to 0.
REQ-022 ISSUE with ciDone=1: capture ciResult, rspTimeout:=0, go RESPOND; else go WAIT.
REQ-023 WAIT: ciStart=0; ciN/ciValueA/ciValueB held at latched values; ciDone=1 -> capture ciResult, rspTimeout:=0, go RESPOND.
REQ-024 WAIT without ciDone: if counter == TIMEOUT-1 -> rspResult:=0, rspTimeout:=1, go RESPOND; else counter+1.
REQ-025 ciDone SHALL take priority over timeout in the same cycle.
REQ-026 ciDone SHALL be ignored in IDLE and RESPOND.
REQ-027 RESPOND: rspValid=1; rspResult/rspTimeout stable until rspReady=1; on rspReady=1 go IDLE.
REQ-028 Outside ISSUE/WAIT: ciN=IDLE_CI, ciValueA=ciValueB=0, ciStart=0.
REQ-029 reqReady SHALL be 0 in all states but IDLE; reqValid there has no effect; no queuing.
REQ-030 Latency: accept at cycle N -> ISSUE N+1 -> earliest rspValid at N+2.
REQ-031 Back-to-back: rspReady in RESPOND at cycle M -> IDLE at M+1 -> next request accepted at M+1 at earliest.
REQ-032 Wait counter SHALL be 8 bits, never wraps (bounded by TIMEOUT-1).

Reset
REQ-033 reset=1 SHALL force IDLE next edge, from any state, overriding all other inputs.
REQ-034 After reset: ciStart=0, ciN=IDLE_CI, ciValueA=ciValueB=0, rspValid=0, rspResult=0, rspTimeout=0, busy=0, reqReady=1, counter=0.
REQ-035 Reset mid-WAIT SHALL drop the pending instruction silently; no response produced.

Verification
REQ-036 Single-cycle CI: req ciN=8'h17, A=2, B=0; ciDone=1 in ISSUE with ciResult=0x1234 -> rspValid at N+2, rspResult=0x1234, rspTimeout=0.
REQ-037 Multi-cycle CI: ciDone after 3 WAIT cycles with ciResult=0xCAFE -> ciStart high exactly one cycle, ciN=8'h17 held throughout, rspResult=0xCAFE.
REQ-038 Timeout TIMEOUT=4, ciDone never: accept N -> ISSUE N+1 -> WAIT N+2..N+5 -> rspValid N+6, rspTimeout=1, rspResult=0, ciN=IDLE_CI at N+6.
REQ-039 Race: ciDone=1 in the WAIT cycle where counter=TIMEOUT-1 -> rspTimeout=0, ciResult captured.
REQ-040 Backpressure: rspReady=0 for 5 cycles -> rspValid/rspResult stable, reqReady=0, new reqValid ignored; rspReady=1 -> IDLE, next request accepted.
REQ-041 Reset in WAIT -> next cycle IDLE, rspValid=0, ciN=IDLE_CI, no response ever emitted for that instruction.
